// File: rtl/pmem_burst_adaptor_pkg.sv
// Shared types and default sizes for the pmem burst adaptor (package pmem_pkg).
// Contents: pmem_state_e FSM encoding, default line/beat/address widths and
// the derived beat count used by the adaptor and its bus interface.
package pmem_pkg;

  localparam int unsigned DEF_LINE_W = 256;
  localparam int unsigned DEF_BEAT_W = 64;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned BEATS      = DEF_LINE_W / DEF_BEAT_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } pmem_state_e;

endpackage

// File: rtl/pmem_burst_adaptor_if.sv
// Bus interface between the dcache controller, the burst adaptor and memory.
// Cache side: line_rd_i/line_wr_i/line_addr_i/line_wdata_i in,
//             line_rdata_o/line_resp_o out.
// Memory side: mem_rd_o/mem_wr_o/mem_addr_o/mem_wdata_o out,
//              mem_rdata_i/mem_resp_i in.
// Modports: slave = adaptor view, master = environment (cache + memory) view.
interface pmem_burst_adaptor_if #(
  parameter int unsigned LINE_W = pmem_pkg::DEF_LINE_W,
  parameter int unsigned BEAT_W = pmem_pkg::DEF_BEAT_W,
  parameter int unsigned ADDR_W = pmem_pkg::DEF_ADDR_W
);

  logic              line_rd_i;
  logic              line_wr_i;
  logic [ADDR_W-1:0] line_addr_i;
  logic [LINE_W-1:0] line_wdata_i;
  logic [LINE_W-1:0] line_rdata_o;
  logic              line_resp_o;
  logic              mem_rd_o;
  logic              mem_wr_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BEAT_W-1:0] mem_wdata_o;
  logic [BEAT_W-1:0] mem_rdata_i;
  logic              mem_resp_i;

  modport slave (
    input  line_rd_i, line_wr_i, line_addr_i, line_wdata_i, mem_rdata_i, mem_resp_i,
    output line_rdata_o, line_resp_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output line_rd_i, line_wr_i, line_addr_i, line_wdata_i, mem_rdata_i, mem_resp_i,
    input  line_rdata_o, line_resp_o, mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/pmem_burst_adaptor.sv
// pmem_burst_adaptor: turns one cache-line transfer into a BEATS-beat memory
// burst (line fill on read, write-back on write) with a single resp pulse.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       cache-side line request and memory-side burst signals
//   rd_bursts_o[31:0] completed read bursts, saturating   (PMEM_STATS_EN only)
//   wr_bursts_o[31:0] completed write bursts, saturating  (PMEM_STATS_EN only)
// Optional feature macro: PMEM_STATS_EN.
module pmem_burst_adaptor
  import pmem_pkg::*;
#(
  parameter int unsigned LINE_W = pmem_pkg::DEF_LINE_W,
  parameter int unsigned BEAT_W = pmem_pkg::DEF_BEAT_W,
  parameter int unsigned ADDR_W = pmem_pkg::DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef PMEM_STATS_EN
  output logic [31:0]           rd_bursts_o,
  output logic [31:0]           wr_bursts_o,
`endif
  pmem_burst_adaptor_if.slave   bus
);

  localparam int unsigned NBEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned OFS_W  = $clog2(LINE_W / 8);

  pmem_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [LINE_W-1:0] r_wbuf;
  logic [LINE_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [BEAT_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_mem_rd, w_mem_rd_nxt;
  logic              r_mem_wr, w_mem_wr_nxt;
  logic              r_resp, w_resp_nxt;
  logic              w_last;
  logic              w_accept_wr;
  logic              w_accept_rd;
  logic              w_unused_ofs;

  // Byte offset within the line plays no part in the burst address.
  assign w_unused_ofs = ^bus.line_addr_i[OFS_W-1:0];

  assign w_last      = (r_cnt == CNT_W'(NBEATS - 1));
  assign w_accept_wr = (r_state == ST_IDLE) && bus.line_wr_i;
  assign w_accept_rd = (r_state == ST_IDLE) && !bus.line_wr_i && bus.line_rd_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and beat counter; write wins when both requests are high
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (bus.line_wr_i)      w_state_nxt = ST_WR_BURST;
        else if (bus.line_rd_i) w_state_nxt = ST_RD_BURST;
      end
      ST_RD_BURST, ST_WR_BURST: begin
        if (bus.mem_resp_i) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop
  always_comb begin
    w_mem_rd_nxt = (w_state_nxt == ST_RD_BURST);
    w_mem_wr_nxt = (w_state_nxt == ST_WR_BURST);
    w_resp_nxt   = (w_state_nxt == ST_DONE);
    w_wdata_nxt  = r_wdata;
    // The buffer is not loaded yet on the accept cycle, so beat 0 comes from the input.
    if (w_accept_wr) begin
      w_wdata_nxt = bus.line_wdata_i[BEAT_W-1:0];
    end else if (w_state_nxt == ST_WR_BURST) begin
      w_wdata_nxt = r_wbuf[w_cnt_nxt*BEAT_W +: BEAT_W];
    end
  end

  // Output registers, line buffers and burst address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_resp   <= 1'b0;
      r_wdata  <= '0;
      r_addr   <= '0;
      r_wbuf   <= '0;
      r_rdata  <= '0;
    end else begin
      r_mem_rd <= w_mem_rd_nxt;
      r_mem_wr <= w_mem_wr_nxt;
      r_resp   <= w_resp_nxt;
      r_wdata  <= w_wdata_nxt;
      if (w_accept_wr) begin
        r_wbuf <= bus.line_wdata_i;
      end
      if (w_accept_wr || w_accept_rd) begin
        r_addr <= {bus.line_addr_i[ADDR_W-1:OFS_W], OFS_W'(0)};
      end
      if ((r_state == ST_RD_BURST) && bus.mem_resp_i) begin
        r_rdata[r_cnt*BEAT_W +: BEAT_W] <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.mem_rd_o     = r_mem_rd;
  assign bus.mem_wr_o     = r_mem_wr;
  assign bus.line_resp_o  = r_resp;
  assign bus.mem_wdata_o  = r_wdata;
  assign bus.mem_addr_o   = r_addr;
  assign bus.line_rdata_o = r_rdata;

`ifdef PMEM_STATS_EN
  logic [31:0] r_rd_bursts;
  logic [31:0] r_wr_bursts;

  // Saturating completed-burst counters, bumped on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bursts <= '0;
      r_wr_bursts <= '0;
    end else begin
      if ((r_state == ST_RD_BURST) && (w_state_nxt == ST_DONE) && (r_rd_bursts != 32'hFFFF_FFFF))
        r_rd_bursts <= r_rd_bursts + 32'd1;
      if ((r_state == ST_WR_BURST) && (w_state_nxt == ST_DONE) && (r_wr_bursts != 32'hFFFF_FFFF))
        r_wr_bursts <= r_wr_bursts + 32'd1;
    end
  end

  assign rd_bursts_o = r_rd_bursts;
  assign wr_bursts_o = r_wr_bursts;
`endif

endmodule
